// File: rtl/hw_pkg.sv
// Shared definitions for the half-word narrowing path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hw_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  // Mode is captured with each word; SPLIT emits both halves, TRUNC the first only.
  localparam logic MODE_SPLIT = 1'b0;
  localparam logic MODE_TRUNC = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

endpackage

// File: rtl/half_select.sv
// Picks one 16-bit half of a 32-bit word: first/second beat, ordered by low_first.
// Latency: combinational.
// Backpressure: none (pure function).
// Ports: i_word (32b word), i_second (1 = second beat), i_low_first (1 = low half leads),
//        o_half (selected 16b half).
module half_select
  import hw_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_second,
  input  logic              i_low_first,
  output logic [HALF_W-1:0] o_half
);

  // Upper half is taken on the second beat of low-first order, or the first
  // beat of high-first order.
  logic w_pick_high;

  assign w_pick_high = i_second ^ ~i_low_first;
  assign o_half      = w_pick_high ? i_word[WORD_W-1:HALF_W] : i_word[HALF_W-1:0];

endmodule

// File: rtl/half_word_serializer.sv
// Narrows 32-bit words to 16-bit beats: SPLIT emits both halves, TRUNC only the low
// half and flags nonzero discarded bits. Latency: first half valid the cycle after
// the word is accepted, no bubbles. Backpressure: one-word holding buffer; InReady
// only when empty or when the final half of the held word leaves this cycle.
// Ports: Clk/Reset (async, active-high); InValid/InReady/InData/InMode upstream;
//        OutValid/OutReady/OutData/OutLast/OutLossy downstream;
//        LossyErr/LossyCnt sticky lossy bookkeeping, cleared by ErrClr.
module half_word_serializer
  import hw_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [WORD_W-1:0] InData,
  input  logic              InMode,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [HALF_W-1:0] OutData,
  output logic              OutLast,
  output logic              OutLossy,
  output logic              LossyErr,
  output logic [CNT_W-1:0]  LossyCnt,
  input  logic              ErrClr
);

  state_t             r_state;
  logic [WORD_W-1:0]  r_held;
  logic               r_mode;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_in_acc;
  logic               w_out_acc;
  logic               w_lossy_acc;
  logic               w_upper_nz;

  // All presented outputs decode from registered state/holding register only,
  // so they cannot change while a beat is stalled.
  assign w_upper_nz = |r_held[WORD_W-1:HALF_W];
  assign OutValid   = (r_state != ST_EMPTY);
  assign OutLast    = (r_state == ST_SECOND) ||
                      ((r_state == ST_FIRST) && (r_mode == MODE_TRUNC));
  assign OutLossy   = (r_state == ST_FIRST) && (r_mode == MODE_TRUNC) && w_upper_nz;

  assign w_out_acc   = OutValid & OutReady;
  assign w_lossy_acc = w_out_acc & OutLossy;

  // Ready also when the last half drains this cycle, so the buffer reloads
  // without a bubble. No dependence on InValid.
  assign InReady  = (r_state == ST_EMPTY) | (w_out_acc & OutLast);
  assign w_in_acc = InValid & InReady;

  assign LossyErr = r_err;
  assign LossyCnt = r_cnt;

  half_select u_half_select (
    .i_word      (r_held),
    .i_second    (r_state == ST_SECOND),
    .i_low_first (LOW_FIRST),
    .o_half      (OutData)
  );

  // Sequencer and holding register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_EMPTY;
      r_held  <= '0;
      r_mode  <= MODE_SPLIT;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_acc) begin
            r_held  <= InData;
            r_mode  <= InMode;
            r_state <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (w_out_acc) begin
            if (r_mode == MODE_SPLIT) begin
              r_state <= ST_SECOND;
            end else if (w_in_acc) begin
              r_held  <= InData;
              r_mode  <= InMode;
              r_state <= ST_FIRST;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        ST_SECOND: begin
          if (w_out_acc) begin
            if (w_in_acc) begin
              r_held  <= InData;
              r_mode  <= InMode;
              r_state <= ST_FIRST;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Lossy bookkeeping. A lossy accept coinciding with a clear counts as the
  // first event after the clear rather than being swallowed by it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_lossy_acc) begin
      r_err <= 1'b1;
      if (ErrClr) begin
        r_cnt <= CNT_W'(1);
      end else if (!(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (ErrClr) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_half_word_serializer.sv
module tb_half_word_serializer;

  logic        Clk;
  logic        Reset;
  logic        clk_run;

  logic        in_vld, in_mode, out_rdy, err_clr;
  logic [31:0] in_dat;
  logic        in_rdy, out_vld, out_last, out_lossy, lossy_err;
  logic [15:0] out_dat;
  logic [7:0]  lossy_cnt;

  logic        h_in_vld, h_in_mode, h_out_rdy;
  logic [31:0] h_in_dat;
  logic        h_in_rdy, h_out_vld, h_out_last, h_out_lossy, h_lossy_err;
  logic [15:0] h_out_dat;
  logic [7:0]  h_lossy_cnt;

  int n_pass;
  int n_total;

  half_word_serializer #(.LOW_FIRST(1'b1), .CNT_W(8)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .InValid(in_vld), .InReady(in_rdy), .InData(in_dat), .InMode(in_mode),
    .OutValid(out_vld), .OutReady(out_rdy), .OutData(out_dat),
    .OutLast(out_last), .OutLossy(out_lossy),
    .LossyErr(lossy_err), .LossyCnt(lossy_cnt), .ErrClr(err_clr)
  );

  half_word_serializer #(.LOW_FIRST(1'b0), .CNT_W(8)) u_dut_hi (
    .Clk(Clk), .Reset(Reset),
    .InValid(h_in_vld), .InReady(h_in_rdy), .InData(h_in_dat), .InMode(h_in_mode),
    .OutValid(h_out_vld), .OutReady(h_out_rdy), .OutData(h_out_dat),
    .OutLast(h_out_last), .OutLossy(h_out_lossy),
    .LossyErr(h_lossy_err), .LossyCnt(h_lossy_cnt), .ErrClr(1'b0)
  );

  initial Clk = 1'b0;
  always begin
    #5;
    if (clk_run) Clk = ~Clk;
  end

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        im;
    logic        ordy;
    logic        clr;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        ey;
    logic        er;
    logic        ee;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int acc_in;
    int acc_lossy;
    int cyc;
    logic seen_vld;

    n_pass = 0; n_total = 0;
    clk_run = 1'b0;
    in_vld = 0; in_dat = '0; in_mode = 0; out_rdy = 0; err_clr = 0;
    h_in_vld = 0; h_in_dat = '0; h_in_mode = 0; h_out_rdy = 0;

    //           iv  id            im ordy clr  ev  ed        el ey er ee ec
    vecs[0]  = '{1, 32'hDEAD_BEEF, 0, 1, 0,   0, 16'h0000, 0, 0, 1, 0, 8'd0};
    vecs[1]  = '{1, 32'h1234_5678, 0, 1, 0,   1, 16'hBEEF, 0, 0, 0, 0, 8'd0};
    vecs[2]  = '{1, 32'h1234_5678, 0, 1, 0,   1, 16'hDEAD, 1, 0, 1, 0, 8'd0};
    vecs[3]  = '{0, 32'h0,         0, 1, 0,   1, 16'h5678, 0, 0, 0, 0, 8'd0};
    vecs[4]  = '{0, 32'h0,         0, 1, 0,   1, 16'h1234, 1, 0, 1, 0, 8'd0};
    vecs[5]  = '{1, 32'h0000_00AA, 1, 1, 0,   0, 16'h0000, 0, 0, 1, 0, 8'd0};
    vecs[6]  = '{1, 32'h0001_0000, 1, 1, 0,   1, 16'h00AA, 1, 0, 1, 0, 8'd0};
    vecs[7]  = '{0, 32'h0,         0, 1, 0,   1, 16'h0000, 1, 1, 1, 0, 8'd0};
    vecs[8]  = '{0, 32'h0,         0, 1, 0,   0, 16'h0000, 0, 0, 1, 1, 8'd1};
    vecs[9]  = '{1, 32'hCAFE_F00D, 0, 0, 0,   0, 16'h0000, 0, 0, 1, 1, 8'd1};
    vecs[10] = '{0, 32'h0,         0, 0, 0,   1, 16'hF00D, 0, 0, 0, 1, 8'd1};
    vecs[11] = '{1, 32'h5555_5555, 1, 0, 0,   1, 16'hF00D, 0, 0, 0, 1, 8'd1};
    vecs[12] = '{0, 32'h0,         1, 0, 0,   1, 16'hF00D, 0, 0, 0, 1, 8'd1};
    vecs[13] = '{0, 32'h0,         0, 0, 0,   1, 16'hF00D, 0, 0, 0, 1, 8'd1};
    vecs[14] = '{0, 32'h0,         0, 0, 0,   1, 16'hF00D, 0, 0, 0, 1, 8'd1};
    vecs[15] = '{0, 32'h0,         1, 1, 0,   1, 16'hF00D, 0, 0, 0, 1, 8'd1};
    vecs[16] = '{0, 32'h0,         0, 1, 0,   1, 16'hCAFE, 1, 0, 1, 1, 8'd1};
    vecs[17] = '{1, 32'hFFFF_0001, 1, 1, 0,   0, 16'h0000, 0, 0, 1, 1, 8'd1};
    vecs[18] = '{0, 32'h0,         0, 1, 1,   1, 16'h0001, 1, 1, 1, 1, 8'd1};
    vecs[19] = '{0, 32'h0,         0, 1, 0,   0, 16'h0000, 0, 0, 1, 1, 8'd1};
    vecs[20] = '{0, 32'h0,         0, 1, 1,   0, 16'h0000, 0, 0, 1, 1, 8'd1};
    vecs[21] = '{0, 32'h0,         0, 0, 0,   0, 16'h0000, 0, 0, 1, 0, 8'd0};

    // Reset held with the clock stopped.
    Reset = 1'b1;
    #3;
    chk("rst OutValid", {31'd0, out_vld}, 32'd0);
    chk("rst OutLast", {31'd0, out_last}, 32'd0);
    chk("rst OutLossy", {31'd0, out_lossy}, 32'd0);
    chk("rst LossyErr", {31'd0, lossy_err}, 32'd0);
    chk("rst LossyCnt", {24'd0, lossy_cnt}, 32'd0);
    chk("rst OutData", {16'd0, out_dat}, 32'd0);
    Reset = 1'b0;
    #1;
    chk("rel InReady", {31'd0, in_rdy}, 32'd1);
    chk("rel OutValid", {31'd0, out_vld}, 32'd0);
    clk_run = 1'b1;
    next_cycle();

    // Table: each row is the input for one cycle and the outputs expected
    // during that same cycle (before the edge that acts on it).
    for (int i = 0; i < 22; i++) begin
      in_vld = vecs[i].iv; in_dat = vecs[i].id; in_mode = vecs[i].im;
      out_rdy = vecs[i].ordy; err_clr = vecs[i].clr;
      #1;
      chk($sformatf("v%0d OutValid", i), {31'd0, out_vld}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d InReady", i), {31'd0, in_rdy}, {31'd0, vecs[i].er});
      chk($sformatf("v%0d OutLast", i), {31'd0, out_last}, {31'd0, vecs[i].el});
      chk($sformatf("v%0d OutLossy", i), {31'd0, out_lossy}, {31'd0, vecs[i].ey});
      chk($sformatf("v%0d LossyErr", i), {31'd0, lossy_err}, {31'd0, vecs[i].ee});
      chk($sformatf("v%0d LossyCnt", i), {24'd0, lossy_cnt}, {24'd0, vecs[i].ec});
      if (vecs[i].ev)
        chk($sformatf("v%0d OutData", i), {16'd0, out_dat}, {16'd0, vecs[i].ed});
      next_cycle();
    end
    in_vld = 0; out_rdy = 0; err_clr = 0;

    // Saturation: 2^8+3 lossy TRUNC beats streamed back to back.
    acc_in = 0; acc_lossy = 0; cyc = 0;
    in_dat = 32'hFFFF_0000; in_mode = 1'b1; out_rdy = 1'b1;
    while (acc_in < 259 && cyc < 400) begin
      in_vld = 1'b1;
      #1;
      if (in_vld && in_rdy) acc_in++;
      if (out_vld && out_rdy && out_lossy) acc_lossy++;
      next_cycle();
      cyc++;
    end
    in_vld = 1'b0;
    cyc = 0;
    #1;
    while (out_vld && cyc < 10) begin
      if (out_rdy && out_lossy) acc_lossy++;
      next_cycle();
      #1;
      cyc++;
    end
    chk("sat drained", {31'd0, out_vld}, 32'd0);
    chk("sat lossy beats", acc_lossy, 32'd259);
    chk("sat LossyCnt", {24'd0, lossy_cnt}, 32'h0000_00FF);
    chk("sat LossyErr", {31'd0, lossy_err}, 32'd1);
    next_cycle();

    // Reset while the second half is pending.
    in_vld = 1'b1; in_dat = 32'hA5A5_5A5A; in_mode = 1'b0; out_rdy = 1'b1;
    next_cycle();
    in_vld = 1'b0;
    next_cycle();
    chk("mid SECOND valid", {31'd0, out_vld}, 32'd1);
    chk("mid SECOND data", {16'd0, out_dat}, 32'h0000_A5A5);
    Reset = 1'b1;
    #1;
    chk("mid rst OutValid", {31'd0, out_vld}, 32'd0);
    chk("mid rst OutLast", {31'd0, out_last}, 32'd0);
    chk("mid rst OutData", {16'd0, out_dat}, 32'd0);
    chk("mid rst LossyErr", {31'd0, lossy_err}, 32'd0);
    chk("mid rst LossyCnt", {24'd0, lossy_cnt}, 32'd0);
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    seen_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_vld) seen_vld = 1'b1;
      next_cycle();
    end
    chk("mid no replay", {31'd0, seen_vld}, 32'd0);
    chk("mid InReady", {31'd0, in_rdy}, 32'd1);
    out_rdy = 1'b0;

    // High-half-first build.
    h_in_vld = 1'b1; h_in_dat = 32'hDEAD_BEEF; h_in_mode = 1'b0; h_out_rdy = 1'b1;
    next_cycle();
    h_in_vld = 1'b0;
    #1;
    chk("hi first data", {16'd0, h_out_dat}, 32'h0000_DEAD);
    chk("hi first last", {31'd0, h_out_last}, 32'd0);
    next_cycle();
    #1;
    chk("hi second data", {16'd0, h_out_dat}, 32'h0000_BEEF);
    chk("hi second last", {31'd0, h_out_last}, 32'd1);
    next_cycle();
    #1;
    chk("hi drained", {31'd0, h_out_vld}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
